scytale_encryption: RTL

//  Streaming scytale (columnar transposition) encryptor; inverse of scytale_decryption.

---
 rtl/scytale_encryption_pkg.sv | 19 +
 rtl/scytale_encryption_if.sv | 27 ++
 rtl/scytale_encryption_addr_gen.sv | 76 +++++++
 rtl/scytale_encryption.sv | 107 ++++++++++
 4 files changed

// File: rtl/scytale_encryption_pkg.sv
// Shared constants and types for the scytale encryptor/decryptor pair.
//   D_WIDTH     : stream byte width
//   KEY_WIDTH   : width of the row/column keys
//   START_TOKEN : end-of-message marker, never stored in the buffer
//   state_e     : top-level FSM states
package scytale_encryption_pkg;

  localparam int D_WIDTH   = 8;
  localparam int KEY_WIDTH = 8;
  localparam int ADDR_W    = 2 * KEY_WIDTH;  // holds N*M without wrap

  localparam logic [D_WIDTH-1:0] START_TOKEN = 8'hFA;

  typedef enum logic {
    IDLE = 1'b0,
    ENC  = 1'b1
  } state_e;

endpackage

// File: rtl/scytale_encryption_if.sv
// Byte-stream bus between a producer/consumer and the scytale encryptor.
//   data_i/valid_i : plaintext byte and qualifier (into the block)
//   key_N/key_M    : row/column keys, sampled only on the token byte
//   data_o/valid_o : ciphertext byte and qualifier (out of the block)
//   busy           : high while the block is emitting ciphertext
interface scytale_encryption_if;
  import scytale_encryption_pkg::*;

  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 busy;

  modport master (
    output data_i, valid_i, key_N, key_M,
    input  data_o, valid_o, busy
  );

  modport slave (
    input  data_i, valid_i, key_N, key_M,
    output data_o, valid_o, busy
  );

endinterface

// File: rtl/scytale_encryption_addr_gen.sv
// Column-major address walker over an N-row x M-column row-major buffer.
// Shared with the decryptor.
//   clk, rst_n : clock, synchronous active-low reset
//   start_i    : latch keys and restart at address 0
//   key_n_i    : row count N (latched on start_i)
//   key_m_i    : column count M (latched on start_i)
//   step_i     : advance to the next address
//   addr_o     : current buffer address i*M + j
//   last_o     : current address is the final one (i==N-1, j==M-1)
module scytale_addr_gen
  import scytale_encryption_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] key_n_i,
  input  logic [KEY_WIDTH-1:0] key_m_i,
  input  logic                 step_i,
  output logic [ADDR_W-1:0]    addr_o,
  output logic                 last_o
);

  logic [KEY_WIDTH-1:0] n_q, n_d;
  logic [KEY_WIDTH-1:0] m_q, m_d;
  logic [KEY_WIDTH-1:0] i_q, i_d;
  logic [KEY_WIDTH-1:0] j_q, j_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 i_wrap;

  assign i_wrap = (i_q == n_q - KEY_WIDTH'(1));
  assign last_o = i_wrap && (j_q == m_q - KEY_WIDTH'(1));
  assign addr_o = addr_q;

  // Row index is the inner loop: stepping a row adds M, finishing a column
  // jumps to the top of the next one (address j+1), so no multiplier.
  always_comb begin
    n_d    = n_q;
    m_d    = m_q;
    i_d    = i_q;
    j_d    = j_q;
    addr_d = addr_q;
    if (start_i) begin
      n_d    = key_n_i;
      m_d    = key_m_i;
      i_d    = '0;
      j_d    = '0;
      addr_d = '0;
    end else if (step_i && !last_o) begin
      if (i_wrap) begin
        i_d    = '0;
        j_d    = j_q + KEY_WIDTH'(1);
        addr_d = ADDR_W'(j_q) + ADDR_W'(1);
      end else begin
        i_d    = i_q + KEY_WIDTH'(1);
        addr_d = addr_q + ADDR_W'(m_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q    <= '0;
      m_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      addr_q <= '0;
    end else begin
      n_q    <= n_d;
      m_q    <= m_d;
      i_q    <= i_d;
      j_q    <= j_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/scytale_encryption.sv
// Streaming scytale (columnar transposition) encryptor.
// Buffers plaintext until START_TOKEN, then emits N*M ciphertext bytes,
// one per cycle, c[j*N+i] = p[i*M+j]; addresses beyond the stored length
// read as zero, which pads short messages.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of the byte-stream interface
//                (data_i, valid_i, key_N, key_M in; data_o, valid_o, busy out)
module scytale_encryption
  import scytale_encryption_pkg::*;
#(
  parameter int MAX_NOF_CHARS = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scytale_encryption_if.slave   bus
);

  localparam int LEN_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int IDX_W = $clog2(MAX_NOF_CHARS);

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic               drain_q;   // every byte sent (or zero key): next edge exits
  logic [D_WIDTH-1:0] data_q;
  logic               valid_q;
  logic               busy_q;

  logic [D_WIDTH-1:0] mem_q [MAX_NOF_CHARS];

  logic               is_tok;
  logic               wr_en;
  logic               start;
  logic               step;
  logic [ADDR_W-1:0]  gen_addr;
  logic               gen_last;
  logic [D_WIDTH-1:0] rd_data;

  assign is_tok = (bus.data_i == START_TOKEN);
  assign wr_en  = (state_q == IDLE) && bus.valid_i && !is_tok &&
                  (len_q < LEN_W'(MAX_NOF_CHARS));
  assign start  = (state_q == IDLE) && bus.valid_i && is_tok;
  assign step   = (state_q == ENC) && !drain_q;

  scytale_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .key_n_i (bus.key_N),
    .key_m_i (bus.key_M),
    .step_i  (step),
    .addr_o  (gen_addr),
    .last_o  (gen_last)
  );

  // Anything at or past the write count is padding; this also keeps the
  // index in range when N*M exceeds the buffer depth.
  assign rd_data = (gen_addr < ADDR_W'(len_q)) ? mem_q[gen_addr[IDX_W-1:0]] : '0;

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[len_q[IDX_W-1:0]] <= bus.data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      drain_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          data_q  <= '0;
          valid_q <= 1'b0;
          if (wr_en) len_q <= len_q + LEN_W'(1);
          if (start) begin
            state_q <= ENC;
            busy_q  <= 1'b1;
            drain_q <= (bus.key_N == '0) || (bus.key_M == '0);
          end
        end
        ENC: begin
          if (!drain_q) begin
            data_q  <= rd_data;
            valid_q <= 1'b1;
            if (gen_last) drain_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            len_q   <= '0;
            drain_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.busy    = busy_q;

endmodule
